cpu_fsm: RTL and testbench

//   Instruction-sequencing FSM for the simple RISC datapath.

---
 rtl/cpu_fsm.sv | 112 +++++++++++
 tb/tb_cpu_fsm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_fsm.sv
// rtl/cpu_fsm.sv - instruction-sequencing FSM for the simple RISC datapath
module cpu_fsm #(
   parameter int INSTR_WIDTH = 16,
   parameter bit ERR_STICKY  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s,
   input  logic [INSTR_WIDTH-1:0] in,
   output logic [INSTR_WIDTH-1:0] ir,
   output logic [3:0]             state,
   output logic                   w,
   output logic                   done,
   output logic                   err
);

   localparam logic [3:0] S_WAIT      = 4'b0000;
   localparam logic [3:0] S_DECODE    = 4'b0001;
   localparam logic [3:0] S_WRITE_IMM = 4'b0010;
   localparam logic [3:0] S_LOAD_AB   = 4'b0011;
   localparam logic [3:0] S_LOAD_B    = 4'b0100;
   localparam logic [3:0] S_LOAD_C    = 4'b0101;
   localparam logic [3:0] S_WRITE_C   = 4'b0110;
   localparam logic [3:0] S_LOAD_S    = 4'b0111;

   logic [3:0]             state_q, state_d;
   logic [INSTR_WIDTH-1:0] ir_q;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   accept;
   logic [2:0]             opcode;
   logic [1:0]             op;

   // Fields are decoded from the latched instruction, which is stable for the whole path
   assign opcode = ir_q[INSTR_WIDTH-1 -: 3];
   assign op     = ir_q[INSTR_WIDTH-4 -: 2];

   // State, instruction latch and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (accept) begin
            ir_q <= in;
         end
      end
   end

   // Next state plus next done/err; done is raised on the edge that returns a legal path to WAIT
   always_comb begin
      state_d = S_WAIT;
      done_d  = 1'b0;
      err_d   = ERR_STICKY ? err_q : 1'b0;
      accept  = 1'b0;
      case (state_q)
         S_WAIT: begin
            if (s) begin
               accept  = 1'b1;
               state_d = S_DECODE;
               err_d   = 1'b0;
            end
         end
         S_DECODE: begin
            case ({opcode, op})
               5'b110_10: state_d = S_WRITE_IMM;
               5'b110_00: state_d = S_LOAD_B;
               5'b101_00: state_d = S_LOAD_AB;
               5'b101_10: state_d = S_LOAD_AB;
               5'b101_01: state_d = S_LOAD_AB;
               5'b101_11: state_d = S_LOAD_B;
               default: begin
                  state_d = S_WAIT;
                  err_d   = 1'b1;
               end
            endcase
         end
         S_WRITE_IMM: begin
            state_d = S_WAIT;
            done_d  = 1'b1;
         end
         // CMP only updates status; ADD/AND go on to write the result
         S_LOAD_AB: state_d = (op == 2'b01) ? S_LOAD_S : S_LOAD_C;
         S_LOAD_B:  state_d = S_LOAD_C;
         S_LOAD_C:  state_d = S_WRITE_C;
         S_WRITE_C: begin
            state_d = S_WAIT;
            done_d  = 1'b1;
         end
         S_LOAD_S: begin
            state_d = S_WAIT;
            done_d  = 1'b1;
         end
         default: state_d = S_WAIT;
      endcase
   end

   // Outputs: w is decoded from the state, everything else comes straight from registers
   always_comb begin
      w     = (state_q == S_WAIT);
      state = state_q;
      ir    = ir_q;
      done  = done_q;
      err   = err_q;
   end

endmodule

// File: tb/tb_cpu_fsm.sv
// tb/tb_cpu_fsm.sv - scoreboard bench for cpu_fsm
module tb_cpu_fsm;

   typedef struct packed {
      logic [3:0]  st;
      logic        w;
      logic        d;
      logic        e;
      logic [15:0] ir;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        s;
   logic [15:0] in_v;
   logic [15:0] ir;
   logic [3:0]  state;
   logic        w;
   logic        done;
   logic        err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   exp_t        exp_q[$];
   string       tag_q[$];
   exp_t        cur_e;
   string       cur_t;

   always #5 clk = ~clk;

   cpu_fsm #(.INSTR_WIDTH(16), .ERR_STICKY(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .s     (s),
      .in    (in_v),
      .ir    (ir),
      .state (state),
      .w     (w),
      .done  (done),
      .err   (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input string t, input logic [3:0] st, input logic d, input logic e,
                       input logic [15:0] irv);
      exp_t x;
      x.st = st;
      x.w  = (st == 4'd0);
      x.d  = d;
      x.e  = e;
      x.ir = irv;
      exp_q.push_back(x);
      tag_q.push_back(t);
   endtask

   // Returns at negedge+1 once the queue has drained to n entries (bounded)
   task automatic wait_size(input int n);
      int i = 0;
      while (exp_q.size() > n && i < 60) begin
         @(negedge clk);
         #1;
         i++;
      end
      check("drain", 32'(exp_q.size()), 32'(n));
      while (exp_q.size() > n) begin
         void'(exp_q.pop_front());
         void'(tag_q.pop_front());
      end
   endtask

   // One start pulse; path is left-aligned nibbles of the states after the accepting edge
   task automatic issue(input string t, input logic [15:0] instr, input logic [19:0] path,
                        input int n, input logic legal);
      @(negedge clk);
      #1;
      s    = 1'b1;
      in_v = instr;
      for (int k = 0; k < n; k++) begin
         logic [3:0] st;
         st = path[19-4*k -: 4];
         if (k == n - 1) push(t, st, legal, !legal, instr);
         else            push(t, st, 1'b0, 1'b0, instr);
      end
      push(t, 4'd0, 1'b0, !legal, instr);
      @(negedge clk);
      #1;
      s = 1'b0;
      wait_size(0);
   endtask

   // Monitor: one expected entry per cycle, compared away from the active edge
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (exp_q.size() != 0) begin
         cur_e = exp_q.pop_front();
         cur_t = tag_q.pop_front();
         check({cur_t, ".state"}, 32'(state), 32'(cur_e.st));
         check({cur_t, ".w"},     32'(w),     32'(cur_e.w));
         check({cur_t, ".done"},  32'(done),  32'(cur_e.d));
         check({cur_t, ".err"},   32'(err),   32'(cur_e.e));
         check({cur_t, ".ir"},    32'(ir),    32'(cur_e.ir));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      s     = 1'b0;
      in_v  = 16'h0000;
      repeat (2) @(negedge clk);
      #1;
      push("reset", 4'd0, 1'b0, 1'b0, 16'h0000);
      push("reset", 4'd0, 1'b0, 1'b0, 16'h0000);
      wait_size(1);
      reset = 1'b0;
      wait_size(0);

      issue("mov_imm",  16'hD105, 20'h12000, 3, 1'b1);
      issue("add",      16'hA0A1, 20'h13560, 5, 1'b1);
      issue("cmp",      16'hA8A1, 20'h13700, 4, 1'b1);
      issue("mov_reg",  16'hC0E0, 20'h14560, 5, 1'b1);
      issue("and",      16'hB0A1, 20'h13560, 5, 1'b1);
      issue("bad_opc",  16'hE000, 20'h10000, 2, 1'b0);
      issue("add2",     16'hA0A1, 20'h13560, 5, 1'b1);
      issue("bad_op",   16'hC800, 20'h10000, 2, 1'b0);

      // s held high across three MVNs: no idle gap, done and w coincide on each restart
      @(negedge clk);
      #1;
      done_cnt = 0;
      s        = 1'b1;
      in_v     = 16'hB860;
      for (int r = 0; r < 3; r++) begin
         push("mvn_b2b", 4'd1, 1'b0, 1'b0, 16'hB860);
         push("mvn_b2b", 4'd4, 1'b0, 1'b0, 16'hB860);
         push("mvn_b2b", 4'd5, 1'b0, 1'b0, 16'hB860);
         push("mvn_b2b", 4'd6, 1'b0, 1'b0, 16'hB860);
         push("mvn_b2b", 4'd0, 1'b1, 1'b0, 16'hB860);
      end
      push("mvn_b2b", 4'd0, 1'b0, 1'b0, 16'hB860);
      wait_size(2);
      s = 1'b0;
      wait_size(0);
      check("b2b_done_count", 32'(done_cnt), 32'd3);

      // Reset while in LOAD_C aborts the ADD without a done pulse
      @(negedge clk);
      #1;
      s    = 1'b1;
      in_v = 16'hA0A1;
      push("rst_mid", 4'd1, 1'b0, 1'b0, 16'hA0A1);
      push("rst_mid", 4'd3, 1'b0, 1'b0, 16'hA0A1);
      push("rst_mid", 4'd5, 1'b0, 1'b0, 16'hA0A1);
      @(negedge clk);
      #1;
      s = 1'b0;
      wait_size(0);
      reset = 1'b1;
      push("rst_mid", 4'd0, 1'b0, 1'b0, 16'h0000);
      push("rst_mid", 4'd0, 1'b0, 1'b0, 16'h0000);
      wait_size(1);
      reset = 1'b0;
      wait_size(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
